// File: rtl/rnbip_pkg.sv
// Shared types and the opcode decoder used by the RNBIP decode/execute hazard logic.
// Maps each opcode onto the register masks it reads and writes, plus its control-transfer class.
package rnbip_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_STALL   = 2'd1,
    ST_RESOLVE = 2'd2,
    ST_FLUSH   = 2'd3
  } ctrl_state_e;

  typedef struct packed {
    logic [7:0] src;
    logic [7:0] dst;
    logic       uncond;
    logic       cond;
  } hz_dec_t;

  // Opcode classes are opcode[7:3]; opcode[2:0] names the register rn.
  localparam logic [4:0] CLS_SYS = 5'b00000;
  localparam logic [4:0] CLS_JC0 = 5'b00001;
  localparam logic [4:0] CLS_MVD = 5'b00010;
  localparam logic [4:0] CLS_MVS = 5'b00011;
  localparam logic [4:0] CLS_NOT = 5'b00100;
  localparam logic [4:0] CLS_JC1 = 5'b00101;
  localparam logic [4:0] CLS_JC2 = 5'b00110;
  localparam logic [4:0] CLS_JC3 = 5'b00111;
  localparam logic [4:0] CLS_INC = 5'b01000;
  localparam logic [4:0] CLS_JC4 = 5'b01001;
  localparam logic [4:0] CLS_DCR = 5'b01010;
  localparam logic [4:0] CLS_MVI = 5'b01011;
  localparam logic [4:0] CLS_STA = 5'b01100;
  localparam logic [4:0] CLS_PSH = 5'b01101;
  localparam logic [4:0] CLS_LDA = 5'b01110;
  localparam logic [4:0] CLS_POP = 5'b01111;

  localparam logic [7:0] OP_RLA = 8'h01;
  localparam logic [7:0] OP_RRA = 8'h02;
  localparam logic [7:0] R0_MASK = 8'h01;

  function automatic hz_dec_t hz_decode(input logic [7:0] opcode);
    hz_dec_t    d;
    logic [7:0] rn_m;
    logic [7:0] one;
    logic       rn_nz;
    d     = '0;
    one   = 8'h01;
    rn_m  = one << opcode[2:0];
    rn_nz = |opcode[2:0];
    if (opcode[7]) begin
      if (opcode[3]) begin
        d.src = rn_m;
        d.dst = rn_m;
      end else begin
        d.src = R0_MASK | rn_m;
        d.dst = R0_MASK;
      end
    end else begin
      case (opcode[7:3])
        CLS_INC, CLS_DCR, CLS_NOT: begin
          d.src = rn_m;
          d.dst = rn_m;
        end
        // rn==0 encodings of MVD/MVS are CLR and RSP, both writing only R0.
        CLS_MVD: begin
          d.src = rn_nz ? R0_MASK : 8'h00;
          d.dst = rn_nz ? rn_m : R0_MASK;
        end
        CLS_MVS: begin
          d.src = rn_nz ? rn_m : 8'h00;
          d.dst = R0_MASK;
        end
        CLS_MVI: d.dst = rn_m;
        CLS_STA: d.src = rn_nz ? (R0_MASK | rn_m) : 8'h00;
        CLS_PSH: d.src = rn_m;
        CLS_LDA, CLS_POP: d.dst = rn_nz ? rn_m : 8'h00;
        CLS_SYS: begin
          if (opcode == OP_RLA || opcode == OP_RRA) begin
            d.src = R0_MASK;
            d.dst = R0_MASK;
          end
          d.uncond = (opcode[2:0] >= 3'd3);
        end
        CLS_JC0, CLS_JC1, CLS_JC2, CLS_JC3, CLS_JC4: d.cond = 1'b1;
        default: d = '0;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/hz_scoreboard.sv
// In-flight destination tracker: one stage per pipeline slot after issue.
// The last stage writes back this cycle and so is excluded from the hazard compare.
module hz_scoreboard
  import rnbip_pkg::*;
#(
  parameter int SB_DEPTH = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_valid,
  input  logic [7:0] push_dst,
  input  logic [7:0] src,
  output logic       hazard
);

  logic       valid_reg [SB_DEPTH];
  logic [7:0] dst_reg   [SB_DEPTH];
  logic [7:0] busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SB_DEPTH; i++) begin
        valid_reg[i] <= 1'b0;
        dst_reg[i]   <= 8'h00;
      end
    end else begin
      valid_reg[0] <= push_valid;
      dst_reg[0]   <= push_valid ? push_dst : 8'h00;
      for (int i = 1; i < SB_DEPTH; i++) begin
        valid_reg[i] <= valid_reg[i-1];
        dst_reg[i]   <= dst_reg[i-1];
      end
    end
  end

  always_comb begin
    busy = 8'h00;
    for (int i = 0; i < SB_DEPTH - 1; i++) begin
      if (valid_reg[i]) busy = busy | dst_reg[i];
    end
  end

  assign hazard = |(src & busy);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Decode-to-execute issue sequencer: stalls on register hazards, resolves
// conditional transfers on the EX flag and squashes wrong-path fetches.
module pipe_hazard_ctrl
  import rnbip_pkg::*;
#(
  parameter int SB_DEPTH  = 3,
  parameter int FLUSH_CYC = 2,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [7:0]       id_opcode,
  input  logic             flag_valid,
  input  logic             flag_taken,
  output logic             id_issue,
  output logic             pc_hold,
  output logic             ex_bubble,
  output logic             flush_ifid,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYC);

  ctrl_state_e      state_reg, state_next;
  logic [2:0]       flush_cnt_reg, flush_cnt_next;
  logic [CNT_W-1:0] stall_cnt_reg;
  hz_dec_t          dec;
  logic             sb_hazard, hazard, can_issue, issue;

  assign dec    = hz_decode(id_opcode);
  assign hazard = id_valid & sb_hazard;

  hz_scoreboard #(.SB_DEPTH(SB_DEPTH)) u_sb (
    .clk        (clk),
    .rst        (rst),
    .push_valid (issue),
    .push_dst   (dec.dst),
    .src        (dec.src),
    .hazard     (sb_hazard)
  );

  always_comb begin
    state_next     = state_reg;
    flush_cnt_next = flush_cnt_reg;
    can_issue      = (state_reg == ST_RUN) || (state_reg == ST_STALL);
    issue          = id_valid & can_issue & ~hazard & ~rst;
    id_issue       = issue;
    ex_bubble      = ~issue & ~rst;
    pc_hold        = ~rst & ((state_reg == ST_RESOLVE) || (can_issue && hazard));
    flush_ifid     = ~rst & (state_reg == ST_FLUSH);
    case (state_reg)
      // Hazard outranks the transfer; a held transfer is re-examined when it finally issues.
      ST_RUN, ST_STALL: begin
        if (issue && dec.uncond) begin
          state_next     = ST_FLUSH;
          flush_cnt_next = FLUSH_INIT;
        end else if (issue && dec.cond) begin
          state_next = ST_RESOLVE;
        end else if (hazard) begin
          state_next = ST_STALL;
        end else begin
          state_next = ST_RUN;
        end
      end
      ST_RESOLVE: begin
        if (flag_valid) begin
          state_next     = flag_taken ? ST_FLUSH : ST_RUN;
          flush_cnt_next = flag_taken ? FLUSH_INIT : flush_cnt_reg;
        end
      end
      ST_FLUSH: begin
        flush_cnt_next = flush_cnt_reg - 3'd1;
        if (flush_cnt_reg <= 3'd1) state_next = ST_RUN;
      end
      default: state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_RUN;
      flush_cnt_reg <= 3'd0;
      stall_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      flush_cnt_reg <= flush_cnt_next;
      if (pc_hold && !(&stall_cnt_reg)) stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  assign ctrl_state = state_reg;
  assign stall_cnt  = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: each step drives one cycle of inputs,
// queues the expected outputs and checks them late in the same cycle.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0;
  logic [7:0] id_opcode = 8'h00;
  logic       flag_valid = 1'b0;
  logic       flag_taken = 1'b0;
  logic       id_issue, pc_hold, ex_bubble, flush_ifid;
  logic [1:0] ctrl_state;
  logic [3:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [1:0] st;
    logic       iss;
    logic       hold;
    logic       bub;
    logic       fl;
    logic [3:0] cnt;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];

  pipe_hazard_ctrl #(.SB_DEPTH(3), .FLUSH_CYC(2), .CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .id_valid   (id_valid),
    .id_opcode  (id_opcode),
    .flag_valid (flag_valid),
    .flag_taken (flag_taken),
    .id_issue   (id_issue),
    .pc_hold    (pc_hold),
    .ex_bubble  (ex_bubble),
    .flush_ifid (flush_ifid),
    .ctrl_state (ctrl_state),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [1:0] st, input logic iss, input logic hold,
                              input logic fl, input logic [3:0] cnt);
    exp_t e;
    e.st   = st;
    e.iss  = iss;
    e.hold = hold;
    e.bub  = ~iss;
    e.fl   = fl;
    e.cnt  = cnt;
    return e;
  endfunction

  task automatic check_out();
    exp_t  e;
    exp_t  obs;
    string tag;
    e   = exp_q.pop_front();
    tag = tag_q.pop_front();
    obs = {ctrl_state, id_issue, pc_hold, ex_bubble, flush_ifid, stall_cnt};
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s: observed st=%0d iss=%b hold=%b bub=%b fl=%b cnt=%0d expected st=%0d iss=%b hold=%b bub=%b fl=%b cnt=%0d",
             tag, obs.st, obs.iss, obs.hold, obs.bub, obs.fl, obs.cnt,
             e.st, e.iss, e.hold, e.bub, e.fl, e.cnt);
    end
  endtask

  task automatic step(input string tag, input logic r, input logic v, input logic [7:0] op,
                      input logic fv, input logic ft, input exp_t e);
    rst        = r;
    id_valid   = v;
    id_opcode  = op;
    flag_valid = fv;
    flag_taken = ft;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    #4;
    check_out();
    @(negedge clk);
  endtask

  // During reset every 1-bit output reads 0 regardless of the decode inputs.
  task automatic do_reset(input string tag);
    step(tag, 1'b1, 1'b1, 8'h43, 1'b0, 1'b0, exp_t'(0));
  endtask

  initial begin
    @(negedge clk);

    // INC R3 then ADI R3: two stall cycles, ADI issues on the third.
    do_reset("rst_a");
    step("inc_issue",  0, 1, 8'h43, 0, 0, mk(0, 1, 0, 0, 0));
    step("adi_haz0",   0, 1, 8'h8B, 0, 0, mk(0, 0, 1, 0, 0));
    step("adi_haz1",   0, 1, 8'h8B, 0, 0, mk(1, 0, 1, 0, 1));
    step("adi_issue",  0, 1, 8'h8B, 0, 0, mk(1, 1, 0, 0, 2));
    step("adi_idle",   0, 0, 8'h00, 0, 0, mk(0, 0, 0, 0, 2));

    // ADA R2, MVS R5 independent; STA R1 waits on R0.
    do_reset("rst_b");
    step("ada_issue",  0, 1, 8'h82, 0, 0, mk(0, 1, 0, 0, 0));
    step("mvs_issue",  0, 1, 8'h1D, 0, 0, mk(0, 1, 0, 0, 0));
    step("sta_haz0",   0, 1, 8'h61, 0, 0, mk(0, 0, 1, 0, 0));
    step("sta_haz1",   0, 1, 8'h61, 0, 0, mk(1, 0, 1, 0, 1));
    step("sta_issue",  0, 1, 8'h61, 0, 0, mk(1, 1, 0, 0, 2));
    step("sta_idle",   0, 0, 8'h00, 0, 0, mk(0, 0, 0, 0, 2));

    // JUA: two flush cycles with the wrong-path opcode bubbled.
    do_reset("rst_c");
    step("jua_issue",  0, 1, 8'h04, 0, 0, mk(0, 1, 0, 0, 0));
    step("jua_flush0", 0, 1, 8'h43, 0, 0, mk(3, 0, 0, 1, 0));
    step("jua_flush1", 0, 1, 8'h43, 0, 0, mk(3, 0, 0, 1, 0));
    step("jua_run",    0, 1, 8'h43, 0, 0, mk(0, 1, 0, 0, 0));

    // JCA not taken then taken; a stray flag in RUN is ignored.
    do_reset("rst_d");
    step("flag_run",   0, 0, 8'h00, 1, 1, mk(0, 0, 0, 0, 0));
    step("jca_issue",  0, 1, 8'h28, 0, 0, mk(0, 1, 0, 0, 0));
    step("jca_wait0",  0, 1, 8'h43, 0, 0, mk(2, 0, 1, 0, 0));
    step("jca_wait1",  0, 1, 8'h43, 0, 0, mk(2, 0, 1, 0, 1));
    step("jca_nt",     0, 1, 8'h43, 1, 0, mk(2, 0, 1, 0, 2));
    step("jca_nt_run", 0, 1, 8'h43, 0, 0, mk(0, 1, 0, 0, 3));
    step("jct_issue",  0, 1, 8'h28, 0, 0, mk(0, 1, 0, 0, 3));
    step("jct_wait",   0, 0, 8'h00, 0, 0, mk(2, 0, 1, 0, 3));
    step("jct_taken",  0, 0, 8'h00, 1, 1, mk(2, 0, 1, 0, 4));
    step("jct_flush0", 0, 0, 8'h00, 0, 0, mk(3, 0, 0, 1, 5));
    step("jct_flush1", 0, 0, 8'h00, 0, 0, mk(3, 0, 0, 1, 5));
    step("jct_run",    0, 0, 8'h00, 0, 0, mk(0, 0, 0, 0, 5));

    // Reset landing in the middle of a flush.
    do_reset("rst_e");
    step("mf_issue",   0, 1, 8'h04, 0, 0, mk(0, 1, 0, 0, 0));
    step("mf_flush",   0, 1, 8'h43, 0, 0, mk(3, 0, 0, 1, 0));
    step("mf_rst",     1, 1, 8'h43, 0, 0, exp_t'(0));
    step("mf_adi",     0, 1, 8'h8B, 0, 0, mk(0, 1, 0, 0, 0));
    step("mf_mvs",     0, 1, 8'h1D, 0, 0, mk(0, 1, 0, 0, 0));

    // Long RESOLVE hold saturates the 4-bit stall counter.
    do_reset("rst_f");
    step("sat_issue",  0, 1, 8'h28, 0, 0, mk(0, 1, 0, 0, 0));
    for (int i = 0; i < 21; i++) begin
      step($sformatf("sat_hold%0d", i), 0, 0, 8'h00, 0, 0,
           mk(2, 0, 1, 0, (i > 15) ? 4'hF : 4'(i)));
    end
    step("sat_nt",     0, 0, 8'h00, 1, 0, mk(2, 0, 1, 0, 4'hF));
    step("sat_run",    0, 0, 8'h00, 0, 0, mk(0, 0, 0, 0, 4'hF));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
